// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encodings, register-address width and scoreboard defaults.
package hazard_ctrl_pkg;

  localparam int REGADDR_WIDTH = 5;
  localparam int NUM_REGS      = 1 << REGADDR_WIDTH;
  localparam int DEF_CNT_WIDTH = 2;
  localparam int FCNT_WIDTH    = 2;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_FLUSH    = 2'd2
  } hz_state_e;

  // A source operand conflicts when it is really read, is not $0 and still has a pending write.
  function automatic logic src_raw(input logic                     used,
                                   input logic [REGADDR_WIDTH-1:0] addr,
                                   input logic                     pending);
    return used && (addr != {REGADDR_WIDTH{1'b0}}) && pending;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register count of writes issued from ID but not yet written back.
// Lookups see a same-cycle writeback already applied; $0 never counts.
module reg_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_issue,
  input  logic [REGADDR_WIDTH-1:0] i_issue_addr,
  input  logic                     i_retire,
  input  logic [REGADDR_WIDTH-1:0] i_retire_addr,
  input  logic [REGADDR_WIDTH-1:0] i_rd_a_addr,
  input  logic [REGADDR_WIDTH-1:0] i_rd_b_addr,
  output logic [CNT_WIDTH-1:0]     o_rd_a_cnt,
  output logic [CNT_WIDTH-1:0]     o_rd_b_cnt,
  output logic                     o_cap_full,
  output logic                     o_sb_err
);

  localparam logic [REGADDR_WIDTH-1:0] ZERO_ADDR = {REGADDR_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]     CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX   = CNT_WIDTH'(MAX_INFLIGHT);

  logic [CNT_WIDTH-1:0] r_cnt [NUM_REGS];
  logic                 r_err;
  logic                 w_issue;
  logic                 w_retire;
  logic [NUM_REGS-1:0]  w_inc_vec;
  logic [NUM_REGS-1:0]  w_dec_vec;
  logic [CNT_WIDTH-1:0] w_wb_cnt;

  function automatic logic [CNT_WIDTH-1:0] bypass_cnt(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic                 hit);
    return (hit && (cnt != CNT_ZERO)) ? (cnt - CNT_ONE) : cnt;
  endfunction

  assign w_issue  = i_issue  && (i_issue_addr  != ZERO_ADDR);
  assign w_retire = i_retire && (i_retire_addr != ZERO_ADDR);

  assign o_rd_a_cnt = bypass_cnt(r_cnt[i_rd_a_addr], w_retire && (i_retire_addr == i_rd_a_addr));
  assign o_rd_b_cnt = bypass_cnt(r_cnt[i_rd_b_addr], w_retire && (i_retire_addr == i_rd_b_addr));
  assign w_wb_cnt   = bypass_cnt(r_cnt[i_issue_addr], w_retire && (i_retire_addr == i_issue_addr));
  assign o_cap_full = (i_issue_addr != ZERO_ADDR) && (w_wb_cnt == CNT_MAX);
  assign o_sb_err   = r_err;

  // One-hot increment/decrement requests for this cycle.
  always_comb begin
    w_inc_vec = {NUM_REGS{1'b0}};
    w_dec_vec = {NUM_REGS{1'b0}};
    if (w_issue) begin
      w_inc_vec[i_issue_addr] = 1'b1;
    end else begin
      w_inc_vec = {NUM_REGS{1'b0}};
    end
    if (w_retire) begin
      w_dec_vec[i_retire_addr] = 1'b1;
    end else begin
      w_dec_vec = {NUM_REGS{1'b0}};
    end
  end

  // Counter array and sticky underflow flag; issue and retire to one register cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_dec_vec[i] && !w_inc_vec[i] && (r_cnt[i] != CNT_ZERO)) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
      if (w_retire && (r_cnt[i_retire_addr] == CNT_ZERO)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: RAW/capacity stalls, memory freeze
// and the ID flush sequence after a taken branch.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REGADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REGADDR_WIDTH-1:0] id_rt_addr,
  input  logic                     id_rs_used,
  input  logic                     id_rt_used,
  input  logic [REGADDR_WIDTH-1:0] id_wb_addr,
  input  logic                     ex_branch_taken,
  input  logic                     mem_busy,
  input  logic                     wb_valid,
  input  logic [REGADDR_WIDTH-1:0] wb_addr,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     bubble_ex,
  output logic                     flush_id,
  output logic                     sb_err
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [FCNT_WIDTH-1:0] FCNT_ZERO  = {FCNT_WIDTH{1'b0}};
  localparam logic [FCNT_WIDTH-1:0] FCNT_ONE   = FCNT_WIDTH'(1);
  localparam logic [FCNT_WIDTH-1:0] FCNT_FULL  = FCNT_WIDTH'(FLUSH_CYCLES);
  localparam logic [FCNT_WIDTH-1:0] FCNT_FIRST = FCNT_WIDTH'(FLUSH_CYCLES - 1);

  hz_state_e              r_state, w_state_nxt;
  logic                   r_pend, w_pend_nxt;
  logic [FCNT_WIDTH-1:0]  r_fcnt, w_fcnt_nxt;
  logic [CNT_WIDTH-1:0]   w_rs_cnt, w_rt_cnt;
  logic                   w_cap_full, w_sb_err;
  logic                   w_hazard, w_issue, w_freeze, w_flush;

  assign w_hazard = id_valid &&
                    (src_raw(id_rs_used, id_rs_addr, w_rs_cnt != CNT_ZERO) ||
                     src_raw(id_rt_used, id_rt_addr, w_rt_cnt != CNT_ZERO) ||
                     w_cap_full);
  assign w_issue  = id_valid && !w_hazard && (r_state == HZ_IDLE) && !mem_busy && !ex_branch_taken;
  assign w_freeze = mem_busy || (r_state == HZ_MEM_WAIT);
  assign w_flush  = (r_state == HZ_FLUSH) || ((r_state == HZ_IDLE) && ex_branch_taken);
  assign sb_err   = w_sb_err && !rst;

  reg_scoreboard #(
    .CNT_WIDTH    (CNT_WIDTH),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .i_issue       (w_issue),
    .i_issue_addr  (id_wb_addr),
    .i_retire      (wb_valid),
    .i_retire_addr (wb_addr),
    .i_rd_a_addr   (id_rs_addr),
    .i_rd_b_addr   (id_rt_addr),
    .o_rd_a_cnt    (w_rs_cnt),
    .o_rd_b_cnt    (w_rt_cnt),
    .o_cap_full    (w_cap_full),
    .o_sb_err      (w_sb_err)
  );

  // State, pending-flush and flush-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HZ_IDLE;
      r_pend  <= 1'b0;
      r_fcnt  <= FCNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Next state; r_fcnt counts flush cycles still owed, including the current one.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      HZ_IDLE: begin
        if (mem_busy) begin
          w_state_nxt = HZ_MEM_WAIT;
          w_pend_nxt  = r_pend || ex_branch_taken;
        end else if (ex_branch_taken) begin
          w_fcnt_nxt = FCNT_FIRST;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = HZ_FLUSH;
          end else begin
            w_state_nxt = HZ_IDLE;
          end
        end else begin
          w_state_nxt = HZ_IDLE;
        end
      end
      HZ_MEM_WAIT: begin
        if (!mem_busy) begin
          w_pend_nxt = 1'b0;
          if (r_pend || ex_branch_taken) begin
            w_state_nxt = HZ_FLUSH;
            w_fcnt_nxt  = FCNT_FULL;
          end else begin
            w_state_nxt = HZ_IDLE;
          end
        end else begin
          w_pend_nxt = r_pend || ex_branch_taken;
        end
      end
      HZ_FLUSH: begin
        if (mem_busy) begin
          w_state_nxt = HZ_MEM_WAIT;
          w_pend_nxt  = 1'b1;
          w_fcnt_nxt  = FCNT_ZERO;
        end else if (r_fcnt <= FCNT_ONE) begin
          w_state_nxt = HZ_IDLE;
          w_fcnt_nxt  = FCNT_ZERO;
        end else begin
          w_fcnt_nxt = r_fcnt - FCNT_ONE;
        end
      end
      default: begin
        w_state_nxt = HZ_IDLE;
        w_pend_nxt  = 1'b0;
        w_fcnt_nxt  = FCNT_ZERO;
      end
    endcase
  end

  // Output priority: memory freeze, then flush, then hazard stall.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (rst) begin
      stall_if = 1'b0;
    end else if (w_freeze) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (w_flush) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (w_hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end else begin
      stall_if = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Vector-table bench for hazard_ctrl (FLUSH_CYCLES=2); expected outputs are
// queued as each vector is driven and compared when the outputs are sampled.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic [4:0] id_rs_addr = 5'd0, id_rt_addr = 5'd0, id_wb_addr = 5'd0, wb_addr = 5'd0;
  logic       ex_branch_taken = 1'b0, mem_busy = 1'b0, wb_valid = 1'b0;
  logic       stall_if, stall_id, bubble_ex, flush_id, sb_err;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_INFLIGHT(3), .CNT_WIDTH(2), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wb_addr(id_wb_addr), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .sb_err(sb_err)
  );

  typedef struct {
    string      name;
    logic       rst, v;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic [4:0] wb;
    logic       br, mb, wbv;
    logic [4:0] wba;
    logic [4:0] exp;   // {stall_if, stall_id, bubble_ex, flush_id, sb_err}
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] exp_q[$];
  string      name_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic add(input string n, input logic r, input logic v,
                     input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                     input logic [4:0] wb, input logic br, input logic mb,
                     input logic wbv, input logic [4:0] wba, input logic [4:0] e);
    vec_t t;
    t.name = n; t.rst = r; t.v = v; t.rs = rs; t.rsu = rsu; t.rt = rt; t.rtu = rtu;
    t.wb = wb; t.br = br; t.mb = mb; t.wbv = wbv; t.wba = wba; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    logic [4:0] act;
    logic [4:0] e;
    string      n;
    @(negedge clk);
    rst = t.rst; id_valid = t.v; id_rs_addr = t.rs; id_rs_used = t.rsu;
    id_rt_addr = t.rt; id_rt_used = t.rtu; id_wb_addr = t.wb;
    ex_branch_taken = t.br; mem_busy = t.mb; wb_valid = t.wbv; wb_addr = t.wba;
    exp_q.push_back(t.exp);
    name_q.push_back(t.name);
    #2;
    act = {stall_if, stall_id, bubble_ex, flush_id, sb_err};
    e   = exp_q.pop_front();
    n   = name_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %b expected %b (stall_if,stall_id,bubble_ex,flush_id,sb_err)", n, act, e);
    end
  endtask

  task automatic hs(input string n, input logic br, input logic mb, input logic [4:0] e);
    vec_t t;
    t.name = n; t.rst = 1'b0; t.v = 1'b0; t.rs = 5'd0; t.rsu = 1'b0; t.rt = 5'd0; t.rtu = 1'b0;
    t.wb = 5'd0; t.br = br; t.mb = mb; t.wbv = 1'b0; t.wba = 5'd0; t.exp = e;
    apply(t);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name           rst v  rs rsu rt rtu wb  br mb wbv wba  exp
    add("rst_busy",      1, 1, 3, 1,  3, 1,  3,  1, 1, 1,  3, 5'b00000);
    add("rst_idle",      1, 0, 0, 0,  0, 0,  0,  0, 0, 0,  0, 5'b00000);
    add("issue3",        0, 1, 0, 0,  0, 0,  3,  0, 0, 0,  0, 5'b00000);
    add("raw3_c1",       0, 1, 3, 1,  5, 1,  4,  0, 0, 0,  0, 5'b11100);
    add("raw3_c2",       0, 1, 3, 1,  5, 1,  4,  0, 0, 0,  0, 5'b11100);
    add("wb3_bypass",    0, 1, 3, 1,  5, 1,  4,  0, 0, 1,  3, 5'b00000);
    add("raw_rs4",       0, 1, 4, 1,  0, 0,  0,  0, 0, 0,  0, 5'b11100);
    add("raw_rt4",       0, 1, 0, 0,  4, 1,  0,  0, 0, 0,  0, 5'b11100);
    add("unused_src4",   0, 1, 4, 0,  4, 0,  0,  0, 0, 0,  0, 5'b00000);
    add("retire4",       0, 0, 0, 0,  0, 0,  0,  0, 0, 1,  4, 5'b00000);
    add("free4",         0, 1, 4, 1,  0, 0,  0,  0, 0, 0,  0, 5'b00000);
    add("r0_src",        0, 1, 0, 1,  0, 0,  0,  0, 0, 0,  0, 5'b00000);
    add("r0_both",       0, 1, 0, 1,  0, 1,  0,  0, 0, 0,  0, 5'b00000);
    add("r0_retire",     0, 1, 0, 1,  0, 0,  0,  0, 0, 1,  0, 5'b00000);
    add("w7_a",          0, 1, 0, 0,  0, 0,  7,  0, 0, 0,  0, 5'b00000);
    add("w7_b",          0, 1, 0, 0,  0, 0,  7,  0, 0, 0,  0, 5'b00000);
    add("w7_c",          0, 1, 0, 0,  0, 0,  7,  0, 0, 0,  0, 5'b00000);
    add("cap7",          0, 1, 0, 0,  0, 0,  7,  0, 0, 0,  0, 5'b11100);
    add("cap7_ret_iss",  0, 1, 0, 0,  0, 0,  7,  0, 0, 1,  7, 5'b00000);
    add("cap7_hold",     0, 1, 0, 0,  0, 0,  7,  0, 0, 0,  0, 5'b11100);
    add("drain7_a",      0, 0, 0, 0,  0, 0,  0,  0, 0, 1,  7, 5'b00000);
    add("drain7_b",      0, 0, 0, 0,  0, 0,  0,  0, 0, 1,  7, 5'b00000);
    add("drain7_c",      0, 0, 0, 0,  0, 0,  0,  0, 0, 1,  7, 5'b00000);
    add("free7",         0, 1, 7, 1,  0, 0,  0,  0, 0, 0,  0, 5'b00000);
    add("br_flush0",     0, 1, 0, 0,  0, 0,  8,  1, 0, 0,  0, 5'b00110);
    add("br_flush1",     0, 1, 0, 0,  0, 0,  8,  0, 0, 0,  0, 5'b00110);
    add("br_no_issue8",  0, 1, 8, 1,  0, 0,  0,  0, 0, 0,  0, 5'b00000);
    add("issue9",        0, 1, 0, 0,  0, 0,  9,  0, 0, 0,  0, 5'b00000);
    add("mb_c1",         0, 1, 9, 1,  0, 0,  0,  0, 1, 0,  0, 5'b11000);
    add("mb_c2_br",      0, 1, 9, 1,  0, 0,  0,  1, 1, 0,  0, 5'b11000);
    add("mb_c3_ret9",    0, 1, 9, 1,  0, 0,  0,  1, 1, 1,  9, 5'b11000);
    add("mb_c4",         0, 1, 9, 1,  0, 0,  0,  1, 1, 0,  0, 5'b11000);
    add("mw_exit",       0, 1, 9, 1,  0, 0,  0,  1, 0, 0,  0, 5'b11000);
    add("pend_flush1",   0, 1, 9, 1,  0, 0,  0,  0, 0, 0,  0, 5'b00110);
    add("pend_flush2",   0, 1, 9, 1,  0, 0,  0,  0, 0, 0,  0, 5'b00110);
    add("free9",         0, 1, 9, 1,  0, 0,  0,  0, 0, 0,  0, 5'b00000);
    add("ret5_zero",     0, 0, 0, 0,  0, 0,  0,  0, 0, 1,  5, 5'b00000);
    add("err_sticky",    0, 0, 0, 0,  0, 0,  0,  0, 0, 0,  0, 5'b00001);
    add("err_br_flush",  0, 0, 0, 0,  0, 0,  0,  1, 0, 0,  0, 5'b00111);
    add("rst_mid_flush", 1, 0, 0, 0,  0, 0,  0,  0, 0, 0,  0, 5'b00000);
    add("post_rst_idle", 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,  0, 5'b00000);
    add("issue10",       0, 1, 0, 0,  0, 0, 10,  0, 0, 0,  0, 5'b00000);
    add("raw10",         0, 1,10, 1,  0, 0,  0,  0, 0, 0,  0, 5'b11100);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // mem_busy arriving in the middle of a flush re-queues the whole flush
    hs("fl_start",    1'b1, 1'b0, 5'b00110);
    hs("fl_mem_busy", 1'b0, 1'b1, 5'b11000);
    hs("fl_mw_exit",  1'b0, 1'b0, 5'b11000);
    hs("fl_redo1",    1'b0, 1'b0, 5'b00110);
    hs("fl_redo2",    1'b0, 1'b0, 5'b00110);
    hs("fl_done",     1'b0, 1'b0, 5'b00000);
    // branch and mem_busy in the same IDLE cycle
    hs("mbbr_same",   1'b1, 1'b1, 5'b11000);
    hs("mbbr_exit",   1'b0, 1'b0, 5'b11000);
    hs("mbbr_fl1",    1'b0, 1'b0, 5'b00110);
    hs("mbbr_fl2",    1'b0, 1'b0, 5'b00110);
    hs("mbbr_done",   1'b0, 1'b0, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
